// File: rtl/bsg_test_node_client.sv
// bsg_test_node_client: FSB ring trace-replay client executing WRITE/READ/ECHO commands with a 2-entry response FIFO
// Ports: clk_i, reset_n_i (async active-low), en_i; command side v_i/data_i/ready_o;
//        response side v_o/data_o/yumi_i (late consume); error_o (sticky), rx_count_o.
// Optional: define BSG_TEST_NODE_CLIENT_STATS_EN to make opcode 3 (STATS) legal.
module bsg_test_node_client #(
    parameter int ring_width_p = 80,
    parameter int master_id_p  = 0,
    parameter int client_id_p  = 1,
    parameter int els_p        = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    en_i,
    input  logic                    v_i,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i,
    output logic                    error_o,
    output logic [15:0]             rx_count_o
);
    localparam int pw = ring_width_p - 16;
    localparam int aw = els_p > 1 ? $clog2(els_p) : 1;

    logic [3:0]              dest, op, resp_op;
    logic [7:0]              addr;
    logic [pw-1:0]           cmd_data, rdata, resp_data, stats_data;
    logic [pw-1:0]           mem [els_p];
    logic [ring_width_p-1:0] fifo [2];
    logic                    hd, accept, dest_ok, addr_ok, mem_op, bad, enq, err_ev, wr;
    logic [1:0]              cnt;

    assign {dest, op, addr, cmd_data} = data_i;

`ifdef BSG_TEST_NODE_CLIENT_STATS_EN
    localparam logic [3:0] max_op = 4'd3;
    logic [7:0] err_cnt;
    assign stats_data = pw'({err_cnt, rx_count_o});
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i)
            err_cnt <= '0;
        else if (err_ev && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
`else
    localparam logic [3:0] max_op = 4'd2;
    assign stats_data = '0;
`endif

    // ready_o deliberately ignores yumi_i to keep the consumer off the accept path
    assign ready_o = reset_n_i & en_i & (cnt != 2'd2);
    assign v_o     = cnt != 2'd0;
    assign data_o  = fifo[hd];

    always_comb begin
        accept    = v_i & ready_o;
        dest_ok   = dest == 4'(client_id_p);
        addr_ok   = {1'b0, addr} < 9'(els_p);
        mem_op    = op == 4'd0 || op == 4'd1;
        bad       = op > max_op || (mem_op && !addr_ok);
        rdata     = mem[addr[aw-1:0]];
        resp_op   = bad ? 4'hF : op | 4'h8;
        resp_data = bad ? pw'(op) : op == 4'd0 ? '0 : op == 4'd1 ? rdata : op == 4'd2 ? cmd_data + 1'b1 : stats_data;
        enq       = accept & dest_ok;
        err_ev    = accept & (!dest_ok | bad);
        wr        = enq & op == 4'd0 & addr_ok;
    end

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            hd         <= 1'b0;
            cnt        <= 2'd0;
            error_o    <= 1'b0;
            rx_count_o <= '0;
            for (int i = 0; i < els_p; i++) mem[i] <= '0;
        end else begin
            if (accept) rx_count_o <= rx_count_o + 16'd1;
            if (err_ev) error_o <= 1'b1;
            if (wr) mem[addr[aw-1:0]] <= cmd_data;
            if (yumi_i) hd <= ~hd;
            cnt <= cnt + 2'(enq) - 2'(yumi_i);
        end

    // tail slot is head+count; a full FIFO never enqueues, so count[0] suffices
    always_ff @(posedge clk_i)
        if (enq) fifo[hd ^ cnt[0]] <= {4'(master_id_p), resp_op, addr, resp_data};
endmodule

// File: tb/tb_bsg_test_node_client.sv
// tb_bsg_test_node_client: vector table, corner sequences and randomized model check of bsg_test_node_client
module tb_bsg_test_node_client;
    localparam int RW = 80, PW = 64, MID = 0, CID = 1, ELS = 16;

    logic clk = 0, reset_n = 0, en = 0, v = 0, yumi = 0;
    logic [RW-1:0] din = '0, dout;
    logic ready, vo, err;
    logic [15:0] rx;
    int checks = 0, errors = 0;

    logic [RW-1:0] q[$];
    logic [PW-1:0] m_mem [ELS];
    logic [15:0] m_rx;
    logic [7:0] m_ec;
    logic m_err;

    typedef struct {
        string name;
        logic [3:0] op;
        logic [7:0] addr;
        logic [PW-1:0] data;
        logic [3:0] exp_op;
        logic [PW-1:0] exp_data;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    bsg_test_node_client #(.ring_width_p(RW), .master_id_p(MID), .client_id_p(CID), .els_p(ELS)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .v_i(v), .data_i(din), .ready_o(ready),
        .v_o(vo), .data_o(dout), .yumi_i(yumi), .error_o(err), .rx_count_o(rx));

    task automatic chk(input string n, input logic [RW-1:0] a, input logic [RW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [RW-1:0] pkt(input logic [3:0] d, input logic [3:0] o, input logic [7:0] a, input logic [PW-1:0] x);
        return {d, o, a, x};
    endfunction

    function automatic logic [RW-1:0] rsp(input logic [3:0] o, input logic [7:0] a, input logic [PW-1:0] x);
        return pkt(4'(MID), o, a, x);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        v = 0; yumi = 0; reset_n = 0;
        tick;
        reset_n = 1;
        q.delete();
        for (int i = 0; i < ELS; i++) m_mem[i] = '0;
        m_rx = 0; m_ec = 0; m_err = 0;
    endtask

    task automatic send_drain(input string n, input logic [RW-1:0] cmd, input logic [RW-1:0] exp);
        din = cmd; v = 1;
        #1 chk({n, "_ready"}, ready, 1);
        tick;
        v = 0;
        chk({n, "_v"}, vo, 1);
        chk({n, "_data"}, dout, exp);
        yumi = 1;
        tick;
        yumi = 0;
        chk({n, "_empty"}, vo, 0);
    endtask

    // reference: response derived straight from the command rules
    task automatic model_accept(input logic [RW-1:0] c);
        logic [3:0] d, o, ro;
        logic [7:0] a;
        logic [PW-1:0] x, r;
        bit bad;
        {d, o, a, x} = c;
        bad = 0; r = '0; ro = o | 4'h8;
        if (d != 4'(CID)) bad = 1;
        else begin
            case (o)
                4'd0: if (a < ELS) m_mem[a[3:0]] = x; else bad = 1;
                4'd1: if (a < ELS) r = m_mem[a[3:0]]; else bad = 1;
                4'd2: r = x + 1;
`ifdef BSG_TEST_NODE_CLIENT_STATS_EN
                4'd3: r = PW'({m_ec, m_rx});
`endif
                default: bad = 1;
            endcase
            if (bad) begin ro = 4'hF; r = PW'(o); end
            q.push_back(rsp(ro, a, r));
        end
        if (bad) begin
            m_err = 1;
            if (m_ec != 8'hFF) m_ec++;
        end
        m_rx++;
    endtask

    initial begin
        tbl[0] = '{"write5", 4'd0, 8'd5, 64'hDEAD_BEEF, 4'h8, 64'd0};
        tbl[1] = '{"read5", 4'd1, 8'd5, 64'd0, 4'h9, 64'hDEAD_BEEF};
        tbl[2] = '{"echo_ones", 4'd2, 8'd0, {PW{1'b1}}, 4'hA, 64'd0};
        tbl[3] = '{"echo7", 4'd2, 8'd3, 64'd7, 4'hA, 64'd8};
        tbl[4] = '{"read16", 4'd1, 8'd16, 64'd0, 4'hF, 64'd1};
        tbl[5] = '{"op6", 4'd6, 8'd2, 64'd0, 4'hF, 64'd6};

        en = 1; reset_n = 0;
        #1;
        chk("reset_ready", ready, 0);
        chk("reset_v", vo, 0);
        chk("reset_err", err, 0);
        chk("reset_rx", rx, 0);
        repeat (2) tick;
        reset_n = 1;
        #1 chk("ready_after_reset", ready, 1);

        for (int i = 0; i < 6; i++) begin
            if (i == 4) chk("no_err_before_bad", err, 0);
            send_drain(tbl[i].name, pkt(4'(CID), tbl[i].op, tbl[i].addr, tbl[i].data),
                       rsp(tbl[i].exp_op, tbl[i].addr, tbl[i].exp_data));
        end
        chk("tbl_err", err, 1);
        chk("tbl_rx", rx, 6);

        do_reset;
        v = 1; din = pkt(4'(CID), 4'd2, 8'd0, 64'd1);
        tick;
        din = pkt(4'(CID), 4'd2, 8'd0, 64'd2);
        tick;
        din = pkt(4'(CID), 4'd2, 8'd0, 64'd3);
        #1;
        chk("bp_ready_full", ready, 0);
        chk("bp_head1", dout, rsp(4'hA, 8'd0, 64'd2));
        yumi = 1;
        tick;
        yumi = 0;
        chk("bp_ready_after_yumi", ready, 1);
        chk("bp_rx2", rx, 2);
        chk("bp_head2", dout, rsp(4'hA, 8'd0, 64'd3));
        tick;
        v = 0;
        chk("bp_rx3", rx, 3);
        yumi = 1;
        tick;
        chk("bp_head3", dout, rsp(4'hA, 8'd0, 64'd4));
        tick;
        yumi = 0;
        chk("bp_drained", vo, 0);

        do_reset;
        v = 1; din = pkt(4'd7, 4'd2, 8'd0, 64'd5);
        tick;
        v = 0;
        chk("misroute_v", vo, 0);
        chk("misroute_err", err, 1);
        chk("misroute_rx", rx, 1);
        v = 1; din = pkt(4'(CID), 4'd2, 8'd0, 64'd9);
        repeat (2) tick;
        v = 0;
        chk("queued2_ready", ready, 0);
        reset_n = 0;
        #1;
        chk("async_rst_v", vo, 0);
        chk("async_rst_err", err, 0);
        chk("async_rst_rx", rx, 0);
        chk("async_rst_ready", ready, 0);
        tick;
        reset_n = 1;
        tick;
        chk("no_replay", vo, 0);

        v = 1; din = pkt(4'(CID), 4'd2, 8'd0, 64'd20);
        tick;
        v = 0; en = 0;
        #1;
        chk("en_drop_ready", ready, 0);
        chk("en_drop_drain", dout, rsp(4'hA, 8'd0, 64'd21));
        yumi = 1;
        tick;
        yumi = 0; en = 1;
        chk("en_drop_empty", vo, 0);

        do_reset;
        send_drain("st_w", pkt(4'(CID), 4'd0, 8'd3, 64'd11), rsp(4'h8, 8'd3, 64'd0));
        send_drain("st_r", pkt(4'(CID), 4'd1, 8'd3, 64'd0), rsp(4'h9, 8'd3, 64'd11));
        send_drain("st_e", pkt(4'(CID), 4'd2, 8'd0, 64'd0), rsp(4'hA, 8'd0, 64'd1));
        send_drain("st_bad", pkt(4'(CID), 4'd6, 8'd0, 64'd0), rsp(4'hF, 8'd0, 64'd6));
`ifdef BSG_TEST_NODE_CLIENT_STATS_EN
        send_drain("stats", pkt(4'(CID), 4'd3, 8'd0, 64'd0), rsp(4'hB, 8'd0, {40'd0, 8'd1, 16'd4}));
`else
        send_drain("stats", pkt(4'(CID), 4'd3, 8'd0, 64'd0), rsp(4'hF, 8'd0, 64'd3));
`endif

        do_reset;
        for (int i = 0; i < 3000; i++) begin
            bit acc;
            en = $urandom_range(0, 7) != 0;
            v = $urandom_range(0, 2) != 0;
            din = pkt($urandom_range(0, 9) == 0 ? 4'd7 : 4'(CID), 4'($urandom_range(0, 6)),
                      8'($urandom_range(0, 19)), {$urandom, $urandom});
            yumi = q.size() != 0 && $urandom_range(0, 1) == 1;
            #1;
            chk("rnd_ready", ready, en && q.size() < 2);
            chk("rnd_v", vo, q.size() != 0);
            if (q.size() != 0) chk("rnd_data", dout, q[0]);
            acc = v && en && q.size() < 2;
            if (yumi) void'(q.pop_front());
            if (acc) model_accept(din);
            tick;
        end
        v = 0; yumi = 0;
        #1;
        chk("rnd_rx", rx, m_rx);
        chk("rnd_err", err, m_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
